// File: rtl/fft_spectrum_sink_if.sv
// fft_spectrum_sink_if: stream, publish-handshake and read-port bundle for
// fft_spectrum_sink. The sink drives its outputs through the slave modport.
// The peak outputs exist only when SPECTRUM_PEAK_EN is defined.
interface fft_spectrum_sink_if #(
    parameter int IDX_W = 10,
    parameter int MAG_W = 17
);
    logic             s_axis_tvalid;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tlast;
    logic [IDX_W-1:0] s_axis_tuser;
    logic             s_axis_tready;
    logic             frame_ready;
    logic             frame_ack;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [MAG_W-1:0] rd_data;
    logic             rd_valid;
    logic             err_len;
`ifdef SPECTRUM_PEAK_EN
    logic [IDX_W-1:0] peak_bin;
    logic [MAG_W-1:0] peak_mag;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser,
        output frame_ack, rd_en, rd_addr,
        input  s_axis_tready, frame_ready, rd_data, rd_valid, err_len,
        input  peak_bin, peak_mag
    );
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser,
        input  frame_ack, rd_en, rd_addr,
        output s_axis_tready, frame_ready, rd_data, rd_valid, err_len,
        output peak_bin, peak_mag
    );
`else
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser,
        output frame_ack, rd_en, rd_addr,
        input  s_axis_tready, frame_ready, rd_data, rd_valid, err_len
    );
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser,
        input  frame_ack, rd_en, rd_addr,
        output s_axis_tready, frame_ready, rd_data, rd_valid, err_len
    );
`endif
endinterface

// File: rtl/fft_spectrum_sink.sv
// fft_spectrum_sink: AXI4-Stream sink for FFT bins. Computes |re|+|im| in a
// 2-stage pipeline, writes it into the fill bank of a ping-pong buffer and
// publishes complete frames through a ready/ack handshake and a 1-cycle
// latency read port. Optional peak tracking: define SPECTRUM_PEAK_EN.
module fft_spectrum_sink #(
    parameter int FRAME_LEN = 1024,
    parameter int IDX_W     = 10,
    parameter int MAG_W     = 17
) (
    input  logic               clk,
    input  logic               rst,
    fft_spectrum_sink_if.slave bus
);
    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_PUBLISH, S_WAIT} state_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             drain_q, drain_d;
    logic             tready_q;
    logic             frame_ready_q, frame_ready_d;
    logic             err_q, err_d;
    logic             w_bank_q;
    logic             swap;
    logic             accept;

    logic             s1_vld, s2_vld;
    logic [15:0]      s1_re_abs, s1_im_abs;
    logic [IDX_W-1:0] s1_addr, s2_addr;
    logic [MAG_W-1:0] s2_mag;

    logic [MAG_W-1:0] mem [0:2*FRAME_LEN-1];
    logic [MAG_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // -32768 wraps back to 0x8000, which read unsigned is 32768.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    assign accept = bus.s_axis_tvalid & tready_q;

    // Magnitude pipeline: stage 1 absolute values, stage 2 sum; bin index rides along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_re_abs <= '0;
            s1_im_abs <= '0;
            s1_addr   <= '0;
            s2_vld    <= 1'b0;
            s2_mag    <= '0;
            s2_addr   <= '0;
        end else begin
            s1_vld    <= accept;
            s1_re_abs <= abs16(bus.s_axis_tdata[15:0]);
            s1_im_abs <= abs16(bus.s_axis_tdata[31:16]);
            s1_addr   <= bus.s_axis_tuser;
            s2_vld    <= s1_vld;
            s2_mag    <= MAG_W'({1'b0, s1_re_abs} + {1'b0, s1_im_abs});
            s2_addr   <= s1_addr;
        end
    end

    // Ping-pong storage: stage-2 results land in the fill bank W.
    always_ff @(posedge clk) begin
        if (s2_vld) mem[{w_bank_q, s2_addr}] <= s2_mag;
    end

    // Read port always addresses the published bank R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= mem[{~w_bank_q, bus.rd_addr}];
        end
    end

    // Frame FSM next state: length checks, pipeline drain, publish/wait handshake.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        drain_d       = drain_q;
        err_d         = 1'b0;
        swap          = 1'b0;
        frame_ready_d = frame_ready_q;
        if (bus.frame_ack && frame_ready_q) frame_ready_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (bus.s_axis_tlast) begin
                            state_d = S_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.s_axis_tlast) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                // An ack in this cycle releases the old frame and publishes at once.
                if (!frame_ready_q || bus.frame_ack) begin
                    swap          = 1'b1;
                    frame_ready_d = 1'b1;
                    state_d       = S_FILL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                frame_ready_d = 1'b1;
                if (bus.frame_ack) begin
                    swap    = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Frame FSM state and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FILL;
            cnt_q         <= '0;
            drain_q       <= 1'b0;
            tready_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            err_q         <= 1'b0;
            w_bank_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            drain_q       <= drain_d;
            tready_q      <= (state_d == S_FILL);
            frame_ready_q <= frame_ready_d;
            err_q         <= err_d;
            w_bank_q      <= w_bank_q ^ swap;
        end
    end

`ifdef SPECTRUM_PEAK_EN
    logic             s1_first, s2_first;
    logic [IDX_W-1:0] run_bin, peak_bin_q;
    logic [MAG_W-1:0] run_mag, peak_mag_q;

    // Peak tracking over stage-2 writes; first bin of a frame restarts the search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_first   <= 1'b0;
            s2_first   <= 1'b0;
            run_bin    <= '0;
            run_mag    <= '0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else begin
            s1_first <= (cnt_q == '0);
            s2_first <= s1_first;
            if (s2_vld && (s2_first || s2_mag > run_mag)) begin
                run_bin <= s2_addr;
                run_mag <= s2_mag;
            end
            if (swap) begin
                peak_bin_q <= run_bin;
                peak_mag_q <= run_mag;
            end
        end
    end

    assign bus.peak_bin = peak_bin_q;
    assign bus.peak_mag = peak_mag_q;
`endif

    assign bus.s_axis_tready = tready_q;
    assign bus.frame_ready   = frame_ready_q;
    assign bus.err_len       = err_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
endmodule

// File: tb/tb_fft_spectrum_sink.sv
// tb_fft_spectrum_sink: randomized frames against a per-bin magnitude model
// of the published frame; scenario tasks cover reset, length errors,
// publish/ack handshake, back-pressure and read latency.
module tb_fft_spectrum_sink;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_spectrum_sink_if #(.IDX_W(10), .MAG_W(17)) bus ();

    fft_spectrum_sink #(.FRAME_LEN(N), .IDX_W(10), .MAG_W(17)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cur_re[N];
    int cur_im[N];
    int pend_mag[N];
    int pub_mag[N];
    int sat_bin;

    function automatic int mag_of(input int re, input int im);
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: re=k, im=-k; kind 1: random with one full-scale bin; kind 2: small values, peak 500 at bins 7 and 9
    task automatic gen_frame(input int kind);
        for (int k = 0; k < N; k++) begin
            if (kind == 0) begin
                cur_re[k] = k;
                cur_im[k] = -k;
            end else if (kind == 1) begin
                cur_re[k] = int'($urandom_range(65535)) - 32768;
                cur_im[k] = int'($urandom_range(65535)) - 32768;
            end else begin
                cur_re[k] = int'($urandom_range(400)) - 200;
                cur_im[k] = int'($urandom_range(400)) - 200;
            end
        end
        if (kind == 1) begin
            sat_bin = int'($urandom_range(N - 1));
            cur_re[sat_bin] = -32768;
            cur_im[sat_bin] = -32768;
        end
        if (kind == 2) begin
            cur_re[7] = 250;  cur_im[7] = -250;
            cur_re[9] = -100; cur_im[9] = 400;
        end
        for (int k = 0; k < N; k++) pend_mag[k] = mag_of(cur_re[k], cur_im[k]);
    endtask

    task automatic send_beat(input int bin, input int re, input int im, input bit last, output bit ok);
        int n;
        bit acc;
        logic [15:0] re16, im16;
        re16 = re[15:0];
        im16 = im[15:0];
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = {im16, re16};
        bus.s_axis_tuser  = 10'(bin);
        bus.s_axis_tlast  = last;
        ok = 1'b0;
        n = 0;
        while (n < 2000 && !ok) begin
            acc = bus.s_axis_tready;
            tick();
            n++;
            if (acc) ok = 1'b1;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (!ok) begin
            errors++; checks++;
            $display("FAIL beat_accept_timeout: bin %0d not accepted, required acceptance within 2000 cycles", bin);
        end
    endtask

    task automatic send_frame(input int nbeats, input int tlast_at);
        bit ok;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(7) == 0) tick();
            send_beat(i, cur_re[i], cur_im[i], (i == tlast_at), ok);
            if (!ok) break;
        end
    endtask

    task automatic check_publish(input string name);
        int n;
        checks++;
        if (bus.s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s_tready_drop: tready=%b required 0", name, bus.s_axis_tready);
        end
        n = 0;
        while (n < 10 && bus.frame_ready !== 1'b1) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL %s_publish_latency: frame_ready after %0d edges, required 3", name, n);
        end
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_tready_back: tready=%b required 1", name, bus.s_axis_tready);
        end
        for (int k = 0; k < N; k++) pub_mag[k] = pend_mag[k];
    endtask

    // Back-to-back reads: two chosen addresses then nrand random ones, one result per cycle
    task automatic read_check(input string name, input int a0, input int a1, input int nrand);
        int a;
        logic [16:0] want;
        bus.rd_en = 1'b1;
        for (int i = 0; i < nrand + 2; i++) begin
            a = (i == 0) ? a0 : (i == 1) ? a1 : int'($urandom_range(N - 1));
            bus.rd_addr = 10'(a);
            tick();
            want = 17'(pub_mag[a]);
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== want) begin
                errors++;
                $display("FAIL %s_read[%0d]: rd_valid=%b rd_data=%0d required valid=1 data=%0d",
                         name, a, bus.rd_valid, bus.rd_data, want);
            end
        end
        bus.rd_en = 1'b0;
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_rd_valid_drop: rd_valid=%b required 0", name, bus.rd_valid);
        end
    endtask

    task automatic release_frame();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.s_axis_tready !== 1'b0 || bus.frame_ready !== 1'b0 || bus.err_len !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tready=%b frame_ready=%b err_len=%b required 0 0 0",
                     bus.s_axis_tready, bus.frame_ready, bus.err_len);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 17'd0) begin
            errors++;
            $display("FAIL reset_read: rd_valid=%b rd_data=%0d required 0 0", bus.rd_valid, bus.rd_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_tready: tready=%b required 0 before first edge", bus.s_axis_tready);
        end
        tick();
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_tready: tready=%b required 1", bus.s_axis_tready);
        end
    endtask

    task automatic test_short_frame();
        gen_frame(1);
        send_frame(500, 499);
        checks++;
        if (bus.err_len !== 1'b1) begin
            errors++;
            $display("FAIL short_err_pulse: err_len=%b required 1", bus.err_len);
        end
        tick();
        checks++;
        if (bus.err_len !== 1'b0 || bus.frame_ready !== 1'b0 || bus.s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL short_after: err_len=%b frame_ready=%b tready=%b required 0 0 1",
                     bus.err_len, bus.frame_ready, bus.s_axis_tready);
        end
        release_frame();
        tick();
        checks++;
        if (bus.frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: frame_ready=%b required 0", bus.frame_ready);
        end
    endtask

    task automatic test_inorder();
        gen_frame(0);
        send_frame(N, N - 1);
        check_publish("inorder");
        read_check("inorder", 5, 1023, 8);
    endtask

    task automatic test_overrun();
        gen_frame(1);
        send_frame(N, -1);
        checks++;
        if (bus.err_len !== 1'b1 || bus.frame_ready !== 1'b1 || bus.s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL overrun: err_len=%b frame_ready=%b tready=%b required 1 1 1",
                     bus.err_len, bus.frame_ready, bus.s_axis_tready);
        end
        read_check("overrun_keep", 0, 5, 6);
    endtask

    task automatic test_ack_release();
        release_frame();
        checks++;
        if (bus.frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: frame_ready=%b required 0", bus.frame_ready);
        end
    endtask

    task automatic test_full_scale();
        gen_frame(1);
        send_frame(N, N - 1);
        check_publish("full_scale");
        read_check("full_scale", sat_bin, 0, 6);
    endtask

    task automatic test_back_to_back();
        release_frame();
        gen_frame(1);
        send_frame(N, N - 1);
        check_publish("b2b_first");
        gen_frame(0);
        for (int k = 0; k < N; k++) pend_mag[k] = mag_of(cur_re[k], cur_im[k]);
        send_frame(N, N - 1);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.s_axis_tready !== 1'b0 || bus.frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait: tready=%b frame_ready=%b required 0 1", bus.s_axis_tready, bus.frame_ready);
        end
        read_check("b2b_old", 3, 1000, 4);
        release_frame();
        checks++;
        if (bus.s_axis_tready !== 1'b1 || bus.frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_swap: tready=%b frame_ready=%b required 1 1", bus.s_axis_tready, bus.frame_ready);
        end
        for (int k = 0; k < N; k++) pub_mag[k] = pend_mag[k];
        read_check("b2b_new", 5, 1023, 6);
    endtask

    task automatic test_ack_on_publish();
        gen_frame(1);
        send_frame(N, N - 1);
        tick();
        tick();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        checks++;
        if (bus.frame_ready !== 1'b1 || bus.s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL ack_on_publish: frame_ready=%b tready=%b required 1 1", bus.frame_ready, bus.s_axis_tready);
        end
        for (int k = 0; k < N; k++) pub_mag[k] = pend_mag[k];
        read_check("ack_on_publish", sat_bin, 1, 6);
    endtask

    task automatic test_reset_mid();
        gen_frame(1);
        send_frame(300, -1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.frame_ready !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: frame_ready=%b tready=%b required 0 0", bus.frame_ready, bus.s_axis_tready);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.frame_ready !== 1'b0 || bus.s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release: frame_ready=%b tready=%b required 0 1", bus.frame_ready, bus.s_axis_tready);
        end
        gen_frame(1);
        send_frame(N, N - 1);
        check_publish("reset_mid_fresh");
        read_check("reset_mid_fresh", 0, 1023, 6);
    endtask

`ifdef SPECTRUM_PEAK_EN
    task automatic test_peak();
        int best_bin;
        int best_mag;
        release_frame();
        gen_frame(2);
        best_bin = 0;
        best_mag = pend_mag[0];
        for (int k = 1; k < N; k++) begin
            if (pend_mag[k] > best_mag) begin
                best_mag = pend_mag[k];
                best_bin = k;
            end
        end
        send_frame(N, N - 1);
        check_publish("peak");
        checks++;
        if (int'(bus.peak_bin) !== best_bin || int'(bus.peak_mag) !== best_mag) begin
            errors++;
            $display("FAIL peak: peak_bin=%0d peak_mag=%0d required %0d %0d",
                     bus.peak_bin, bus.peak_mag, best_bin, best_mag);
        end
    endtask
`endif

    initial begin
        rst               = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = '0;
        bus.frame_ack     = 1'b0;
        bus.rd_en         = 1'b0;
        bus.rd_addr       = '0;
        test_reset();
        test_short_frame();
        test_inorder();
        test_overrun();
        test_ack_release();
        test_full_scale();
        test_back_to_back();
        test_ack_on_publish();
        test_reset_mid();
`ifdef SPECTRUM_PEAK_EN
        test_peak();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at 5 ms, required completion earlier");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fft_spectrum_sink.md
# fft_spectrum_sink

AXI4-Stream sink for the FFT core's result stream. Accepts one complex bin per beat, computes an L1 magnitude (|re|+|im|), and writes it into a ping-pong frame buffer indexed by bin number. It then publishes each complete frame to the display/readout logic through a random-access read port with a ready/ack handshake. It is the consumer at the output end of the FFT stream that the acquisition top feeds.

## Interface
Parameters:
- FRAME_LEN, 1024: bins per FFT frame; must be a power of two.
- IDX_W, 10: log2(FRAME_LEN); width of bin index and read address.
- MAG_W, 17: magnitude width; fixed by the 16-bit re/im inputs.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  FFT output beat valid.
- s_axis_tdata  in  32  [15:0] = re, [31:16] = im, both two's complement.
- s_axis_tlast  in  1  last bin of the frame.
- s_axis_tuser  in  IDX_W  bin index of the beat.
- s_axis_tready  out  1  sink can accept a beat.
- frame_ready  out  1  a published frame is readable.
- frame_ack  in  1  one-cycle pulse from the reader releasing the published frame.
- rd_en  in  1  read request.
- rd_addr  in  IDX_W  bin to read.
- rd_data  out  MAG_W  magnitude of the requested bin.
- rd_valid  out  1  rd_data valid.
- err_len  out  1  one-cycle pulse when a malformed frame is discarded.

## Operation
- A beat is accepted when s_axis_tvalid and s_axis_tready are both high in the same cycle. No other condition accepts a beat.
- Magnitude pipeline, 2 stages:
  - stage 1 registers |re| and |im|; abs(-32768) = 32768.
  - stage 2 registers the sum, zero-extended to 17 bits, with no saturation. The maximum value is 65536.
- The write address is s_axis_tuser, carried through the pipeline. The write bank is W; the other bank, R, is the read bank.
- A beat counter counts accepted beats in the current frame.
- FSM states:
  - FILL: tready = 1. On an accepted beat with tlast:
    - if count+1 == FRAME_LEN, go to DRAIN;
    - otherwise pulse err_len, reset the counter and stay in FILL. The frame is discarded and bank W is reused.
  - FILL, length overrun: if count+1 == FRAME_LEN on a beat without tlast, pulse err_len. Reset the counter, stay in FILL, and discard the frame.
  - DRAIN: tready = 0 for exactly 2 cycles while the pipeline flushes, then go to PUBLISH.
  - PUBLISH: tready = 0.
    - If no frame is published, or frame_ack arrives this cycle: swap W and R, set frame_ready, go to FILL.
    - Otherwise go to WAIT.
  - WAIT: tready = 0. On frame_ack, swap banks, keep frame_ready = 1 (the new frame), go to FILL.
- frame_ready is cleared by frame_ack when no completed frame is pending.
- frame_ack while frame_ready = 0 is ignored.
- Reads always target bank R, even while frame_ready = 0; the contents are then stale.

## Timing
- Reset values:
  - s_axis_tready = 0; it rises on the first clk edge after rst deasserts.
  - frame_ready, rd_valid, rd_data, err_len = 0.
  - FSM = FILL, counter = 0, W = bank 0.
- Write latency: a beat accepted at edge t is written to RAM at edge t+2.
- Publish: frame_ready rises at edge t+3 after the accepted tlast beat if no frame is pending; otherwise it stays high and the bank swaps in the cycle frame_ack is sampled.
- Read latency: 1 cycle. rd_en at edge t gives rd_data and rd_valid at t+1. rd_valid is a one-cycle pulse per request; back-to-back reads give one result per cycle.
- tready is a registered output and does not depend combinationally on tvalid.
- Reset mid-frame: the partial frame is lost, the published frame is lost, and frame_ready drops immediately because reset is asynchronous.
- Simultaneous frame_ack and the PUBLISH cycle: treated as a release followed by a publish, with no WAIT cycle.
- err_len and a valid completion are mutually exclusive within a frame.

## Configuration
- SPECTRUM_PEAK_EN defined:
  - adds outputs peak_bin [IDX_W-1:0] and peak_mag [MAG_W-1:0];
  - the peak is tracked over stage-2 writes, strict greater-than, so the lowest bin wins ties; bin 0 (DC) is included;
  - the outputs are updated together with frame_ready (they describe the published frame) and reset to 0.
- Undefined: the ports and logic are absent; everything else is identical.

## Test plan
- In-order frame, bin k has re=k, im=-k, tlast on bin 1023 → frame_ready at tlast+3; rd_addr=5 gives rd_data=10 one cycle later; rd_addr=1023 gives 2046.
- Bin with re=-32768, im=-32768 → rd_data = 65536, no overflow.
- Tlast on beat 500 → err_len pulse, frame_ready stays 0. The next full frame publishes normally.
- Two complete frames without frame_ack → the second frame ends in WAIT with tready=0. frame_ack → banks swap, the second frame's data is readable, and tready returns to 1.
- Assert rst during beat 300 of a frame while a frame is published → frame_ready=0 immediately and tready=0. After release, a fresh frame publishes into bank 0 data order.
- With SPECTRUM_PEAK_EN defined: bins 7 and 9 both hold magnitude 500, the maximum in the frame → peak_bin=7, peak_mag=500 when frame_ready rises.
